// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch queue feeding the IF/ID pipeline register
//
// Owns the fetch PC, issues in-order word requests to a variable-latency
// instruction memory and buffers up to DEPTH {pc, instr} pairs. One
// instruction per cycle is offered to IF/ID; retain holds the head and
// redirect discards everything in flight.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   imem_req_valid/addr/ready     request channel (word-aligned byte address)
//   imem_resp_valid/data          in-order response channel
//   redirect, redirect_pc         branch/jump from EX/MEM (bits [1:0] ignored)
//   retain                        hazard-unit stall, head is not consumed
//   instr_valid, instr_out, pc_out  head entry (outputs 0 when not valid)
//   resp_error                    sticky: response with nothing outstanding

module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        retain,
    output logic        instr_valid,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic        resp_error
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW:0] DEPTH_W = (PW + 1)'(DEPTH);

    logic [31:0]       pc_mem    [DEPTH];
    logic [31:0]       instr_mem [DEPTH];
    logic [DEPTH-1:0]  filled;
    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;
    logic [PW-1:0]     fill;
    logic [PW-1:0]     drop_cnt;
    logic [31:0]       fetch_pc;

    logic [PW-1:0]     count;
    logic [PW-1:0]     unfilled;
    logic [PW:0]       in_flight;
    logic              req_fire;
    logic              resp_drop;
    logic              resp_fill;
    logic              resp_used;
    logic              pop;
    logic [PW-1:0]     redirect_drop;

    assign count    = tail - head;
    assign unfilled = tail - fill;

    // Buffered entries plus responses still to be discarded; capping this
    // at DEPTH keeps drop_cnt from ever exceeding its width.
    assign in_flight = {1'b0, count} + {1'b0, drop_cnt};

    assign imem_req_valid = !rst && (in_flight < DEPTH_W);
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // Pending drops always belong to requests older than any live entry.
    assign resp_drop = imem_resp_valid && (drop_cnt != '0);
    assign resp_fill = imem_resp_valid && (drop_cnt == '0) && (unfilled != '0);
    assign resp_used = resp_drop || resp_fill;

    assign instr_valid = (count != '0) && filled[head[AW-1:0]];
    assign instr_out   = instr_valid ? instr_mem[head[AW-1:0]] : 32'h0;
    assign pc_out      = instr_valid ? pc_mem[head[AW-1:0]]    : 32'h0;
    assign pop         = instr_valid && !retain && !redirect;

    // Everything issued but not yet answered must be thrown away on a
    // redirect, including a request accepted in the redirect cycle itself.
    assign redirect_drop = unfilled + drop_cnt
                         + {{(PW-1){1'b0}}, req_fire}
                         - {{(PW-1){1'b0}}, resp_used};

    always_ff @(posedge clk) begin
        if (rst) begin
            head       <= '0;
            tail       <= '0;
            fill       <= '0;
            drop_cnt   <= '0;
            filled     <= '0;
            fetch_pc   <= RESET_PC;
            resp_error <= 1'b0;
        end else begin
            if (resp_drop) begin
                drop_cnt <= drop_cnt - 1'b1;
            end else if (resp_fill) begin
                instr_mem[fill[AW-1:0]] <= imem_resp_data;
                filled[fill[AW-1:0]]    <= 1'b1;
                fill                    <= fill + 1'b1;
            end else if (imem_resp_valid) begin
                resp_error <= 1'b1;
            end

            // fill and tail slots cannot alias here: a full queue never issues.
            if (req_fire) begin
                pc_mem[tail[AW-1:0]] <= fetch_pc;
                filled[tail[AW-1:0]] <= 1'b0;
                tail                 <= tail + 1'b1;
                fetch_pc             <= fetch_pc + 32'd4;
            end

            if (pop) begin
                head <= head + 1'b1;
            end

            // Placed last so it overrides every update above.
            if (redirect) begin
                head     <= '0;
                tail     <= '0;
                fill     <= '0;
                filled   <= '0;
                fetch_pc <= {redirect_pc[31:2], 2'b00};
                drop_cnt <= redirect_drop;
            end
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed self-checking bench for fetch_queue

module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b0;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        retain = 1'b0;
    logic        instr_valid;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic        resp_error;

    int n_cmp = 0;
    int n_bad = 0;

    // memory model controls
    int cyc = 0;
    int lat_fixed = 1;
    bit lat_mode = 1'b0;
    bit ready_mode = 1'b0;
    int max_accept = 1000000;
    int accept_cnt = 0;
    int push_idx = 0;
    int due_q[$];
    logic [31:0] addr_q[$];
    logic        mem_rv = 1'b0;
    logic [31:0] mem_rd = 32'h0;
    logic        spur = 1'b0;

    assign imem_resp_valid = mem_rv | spur;
    assign imem_resp_data  = spur ? 32'hDEAD_BEEF : mem_rd;

    fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect        (redirect),
        .redirect_pc     (redirect_pc),
        .retain          (retain),
        .instr_valid     (instr_valid),
        .instr_out       (instr_out),
        .pc_out          (pc_out),
        .resp_error      (resp_error)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Record handshakes with the pre-edge view of the DUT outputs.
    always @(posedge clk) begin
        if (rst) begin
            due_q.delete();
            addr_q.delete();
            accept_cnt = 0;
            push_idx   = 0;
        end else if (imem_req_valid && imem_req_ready) begin
            due_q.push_back(cyc + (lat_mode ? 1 + (push_idx % 5) : lat_fixed));
            addr_q.push_back(imem_req_addr);
            accept_cnt = accept_cnt + 1;
            push_idx   = push_idx + 1;
        end
    end

    // Present responses in order and decide ready for the coming edge.
    always @(negedge clk) begin
        int          d;
        logic [31:0] a;
        mem_rv = 1'b0;
        mem_rd = 32'h0;
        if (!rst && due_q.size() > 0 && due_q[0] <= cyc) begin
            d = due_q.pop_front();
            a = addr_q.pop_front();
            mem_rv = 1'b1;
            mem_rd = mdata(a);
        end
        imem_req_ready = (accept_cnt < max_accept) && (!ready_mode || (cyc % 3) != 0);
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        redirect = 1'b0;
        spur = 1'b0;
        step();
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic set_mem(input int lat, input bit lmode, input bit rmode, input int maxa);
        lat_fixed  = lat;
        lat_mode   = lmode;
        ready_mode = rmode;
        max_accept = maxa;
    endtask

    task automatic test_reset();
        set_mem(1, 0, 0, 1000000);
        retain = 1'b0;
        rst = 1'b1;
        redirect = 1'b1;
        redirect_pc = 32'h0000_0200;
        step();
        step();
        n_cmp++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL reset_req_valid got %b want 0", imem_req_valid); end
        n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL reset_instr_valid got %b want 0", instr_valid); end
        n_cmp++; if (instr_out !== 32'h0) begin n_bad++; $display("FAIL reset_instr_out got %h want 0", instr_out); end
        n_cmp++; if (pc_out !== 32'h0) begin n_bad++; $display("FAIL reset_pc_out got %h want 0", pc_out); end
        n_cmp++; if (resp_error !== 1'b0) begin n_bad++; $display("FAIL reset_resp_error got %b want 0", resp_error); end
        rst = 1'b0;
        redirect = 1'b0;
        #1;
        n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
            n_bad++; $display("FAIL first_req got v=%b a=%h want v=1 a=00000000", imem_req_valid, imem_req_addr);
        end
    endtask

    task automatic test_stream();
        set_mem(1, 0, 0, 1000000);
        retain = 1'b0;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            if (i > 0) step();
            n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'(4 * i)) begin
                n_bad++; $display("FAIL stream_req c%0d got v=%b a=%h want v=1 a=%h", i, imem_req_valid, imem_req_addr, 32'(4 * i));
            end
            n_cmp++; if (instr_valid !== (i >= 2)) begin
                n_bad++; $display("FAIL stream_valid c%0d got %b want %b", i, instr_valid, i >= 2);
            end
            if (i >= 2) begin
                n_cmp++; if (pc_out !== 32'(4 * (i - 2)) || instr_out !== mdata(32'(4 * (i - 2)))) begin
                    n_bad++; $display("FAIL stream_data c%0d got pc=%h ins=%h want pc=%h", i, pc_out, instr_out, 32'(4 * (i - 2)));
                end
            end
        end
    endtask

    task automatic test_full_stall();
        int hs = 0;
        logic [31:0] exp_pc;
        set_mem(1, 0, 0, 1000000);
        retain = 1'b1;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            if (i > 0) step();
            if (imem_req_valid && imem_req_ready) hs++;
        end
        n_cmp++; if (hs != 4) begin n_bad++; $display("FAIL full_req_count got %0d want 4", hs); end
        n_cmp++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL full_req_valid got %b want 0", imem_req_valid); end
        n_cmp++; if (instr_valid !== 1'b1 || pc_out !== 32'h0) begin
            n_bad++; $display("FAIL full_head got v=%b pc=%h want v=1 pc=00000000", instr_valid, pc_out);
        end
        retain = 1'b0;
        for (int i = 1; i < 4; i++) begin
            step();
            exp_pc = 32'(4 * i);
            n_cmp++; if (instr_valid !== 1'b1 || pc_out !== exp_pc || instr_out !== mdata(exp_pc)) begin
                n_bad++; $display("FAIL release_data %0d got v=%b pc=%h ins=%h want pc=%h", i, instr_valid, pc_out, instr_out, exp_pc);
            end
            if (i == 1) begin
                n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h10) begin
                    n_bad++; $display("FAIL release_req got v=%b a=%h want v=1 a=00000010", imem_req_valid, imem_req_addr);
                end
            end
        end
    endtask

    task automatic test_var_latency();
        logic [31:0] exp_pc = 32'h0;
        int got = 0;
        set_mem(1, 1, 1, 1000000);
        retain = 1'b0;
        do_reset();
        for (int k = 0; k < 300 && got < 12; k++) begin
            step();
            retain = (k % 4 == 1);
            if (instr_valid && !retain) begin
                n_cmp++; if (pc_out !== exp_pc || instr_out !== mdata(exp_pc)) begin
                    n_bad++; $display("FAIL varlat_data #%0d got pc=%h ins=%h want pc=%h ins=%h", got, pc_out, instr_out, exp_pc, mdata(exp_pc));
                end
                exp_pc = exp_pc + 32'd4;
                got++;
            end
        end
        retain = 1'b0;
        n_cmp++; if (got != 12) begin n_bad++; $display("FAIL varlat_count got %0d want 12", got); end
    endtask

    task automatic test_redirect();
        int got = 0;
        set_mem(4, 0, 0, 3);
        retain = 1'b0;
        do_reset();
        step();
        step();
        step();
        redirect = 1'b1;
        redirect_pc = 32'h0000_0103;
        lat_fixed = 1;
        max_accept = 1000000;
        n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL redir_cycle_valid got %b want 0", instr_valid); end
        step();
        redirect = 1'b0;
        n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin
            n_bad++; $display("FAIL redir_req got v=%b a=%h want v=1 a=00000100", imem_req_valid, imem_req_addr);
        end
        for (int k = 0; k < 40 && got < 2; k++) begin
            if (k > 0) step();
            if (instr_valid) begin
                n_cmp++; if (pc_out !== 32'(32'h100 + 4 * got) || instr_out !== mdata(32'(32'h100 + 4 * got))) begin
                    n_bad++; $display("FAIL redir_first_data #%0d got pc=%h ins=%h want pc=%h", got, pc_out, instr_out, 32'(32'h100 + 4 * got));
                end
                got++;
            end
        end
        n_cmp++; if (got != 2) begin n_bad++; $display("FAIL redir_timeout got %0d want 2", got); end
    endtask

    task automatic test_redirect_retain();
        set_mem(1, 0, 0, 1000000);
        retain = 1'b1;
        do_reset();
        step();
        step();
        n_cmp++; if (instr_valid !== 1'b1 || pc_out !== 32'h0 || !(imem_req_valid && imem_req_ready)) begin
            n_bad++; $display("FAIL rr_cycle got v=%b pc=%h hs=%b want v=1 pc=00000000 hs=1", instr_valid, pc_out, imem_req_valid && imem_req_ready);
        end
        redirect = 1'b1;
        redirect_pc = 32'h0000_0203;
        step();
        redirect = 1'b0;
        n_cmp++; if (instr_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin
            n_bad++; $display("FAIL rr_after got v=%b rv=%b a=%h want v=0 rv=1 a=00000200", instr_valid, imem_req_valid, imem_req_addr);
        end
        step();
        n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL rr_drop_valid got %b want 0", instr_valid); end
        step();
        n_cmp++; if (instr_valid !== 1'b1 || pc_out !== 32'h200 || instr_out !== mdata(32'h200)) begin
            n_bad++; $display("FAIL rr_resume got v=%b pc=%h ins=%h want v=1 pc=00000200", instr_valid, pc_out, instr_out);
        end
        step();
        n_cmp++; if (instr_valid !== 1'b1 || pc_out !== 32'h200) begin
            n_bad++; $display("FAIL rr_hold got v=%b pc=%h want v=1 pc=00000200", instr_valid, pc_out);
        end
        retain = 1'b0;
        step();
        n_cmp++; if (instr_valid !== 1'b1 || pc_out !== 32'h204) begin
            n_bad++; $display("FAIL rr_next got v=%b pc=%h want v=1 pc=00000204", instr_valid, pc_out);
        end
    endtask

    task automatic test_spurious();
        set_mem(1, 0, 0, 0);
        retain = 1'b0;
        do_reset();
        n_cmp++; if (resp_error !== 1'b0) begin n_bad++; $display("FAIL spur_pre got %b want 0", resp_error); end
        spur = 1'b1;
        step();
        spur = 1'b0;
        n_cmp++; if (resp_error !== 1'b1) begin n_bad++; $display("FAIL spur_set got %b want 1", resp_error); end
        n_cmp++; if (instr_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
            n_bad++; $display("FAIL spur_queue got v=%b rv=%b a=%h want v=0 rv=1 a=00000000", instr_valid, imem_req_valid, imem_req_addr);
        end
        step();
        step();
        step();
        n_cmp++; if (resp_error !== 1'b1) begin n_bad++; $display("FAIL spur_sticky got %b want 1", resp_error); end
        rst = 1'b1;
        step();
        n_cmp++; if (resp_error !== 1'b0) begin n_bad++; $display("FAIL spur_clear got %b want 0", resp_error); end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_full_stall();
        test_var_latency();
        test_redirect();
        test_redirect_retain();
        test_spurious();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch front-end sitting directly upstream of the IF/ID pipeline register. It owns the fetch PC and issues in-order requests to a variable-latency instruction memory, buffering up to DEPTH instructions with their PCs. It presents one instruction per cycle to IF/ID, honours the hazard unit's retain (stall), and discards all stale work on a branch/jump redirect from the EX/MEM stage.

## Interface
- DEPTH, 4, queue entries; power of two, 2..16; bounds the number of requests in flight plus instructions buffered
- RESET_PC, 32'h0000_0000, fetch PC after reset
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- imem_req_valid  out  1  request valid
- imem_req_addr  out  32  request byte address (word aligned)
- imem_req_ready  in  1  memory accepts request this cycle
- imem_resp_valid  in  1  response valid; responses return in request order, at least 1 cycle after acceptance
- imem_resp_data  in  32  instruction word
- redirect  in  1  branch taken / jump from EX/MEM
- redirect_pc  in  32  new fetch PC; bits [1:0] ignored (treated as 0)
- retain  in  1  stall from hazard unit; head is not consumed
- instr_valid  out  1  head entry filled
- instr_out  out  32  head instruction; 0 when instr_valid=0
- pc_out  out  32  head PC; 0 when instr_valid=0
- resp_error  out  1  sticky: response arrived with nothing outstanding

## Operation
- Circular queue of DEPTH entries {pc, instr, filled}; head/tail pointers of log2(DEPTH)+1 bits (wrap bit distinguishes full from empty); count = tail - head.
- Allocate at request: imem_req_valid = (count < DEPTH) && !rst, computed from registered state only. A handshake (valid && ready) writes pc = fetch_pc at tail, filled=0, then tail+1 and fetch_pc+4 (32-bit wrap, 0xFFFF_FFFC -> 0x0000_0000).
- imem_req_addr = fetch_pc whenever imem_req_valid=1.
- Fill at response: the oldest unfilled entry, tracked by a fill pointer, receives imem_resp_data and filled=1, unless drop_cnt > 0. In that case the response is discarded and drop_cnt decrements.
- Consume: instr_valid = head entry filled. Pop when instr_valid && !retain && !redirect.
- Redirect (highest priority, overrides retain):
  - head = tail = fill pointer reset to 0.
  - fetch_pc = {redirect_pc[31:2], 2'b00}.
  - drop_cnt = outstanding + (req handshake this cycle) - (resp consumed this cycle, dropped or filled). Here outstanding = entries allocated but not yet filled, plus any drop_cnt already pending.
- Issue blocking: no new request while drop_cnt > 0 would overflow its width. drop_cnt width is log2(DEPTH)+1 and saturates by construction, because total in flight never exceeds DEPTH.
- Unexpected response: a response with no unfilled entry and drop_cnt=0 is ignored and sets resp_error. Only rst clears resp_error.

## Timing
- Reset values: fetch_pc=RESET_PC, head=tail=fill=0, drop_cnt=0, all filled=0, resp_error=0.
- Resulting outputs in reset: imem_req_valid=0, instr_valid=0, instr_out=0, pc_out=0.
- First request: imem_req_valid=1 in the first cycle after rst deasserts, with addr=RESET_PC.
- Latency: response in cycle n makes instr_valid=1 in cycle n+1. There is no combinational resp→instr bypass.
- Throughput: with 1-cycle memory and no retain, one instruction per cycle sustained. This requires DEPTH ≥ 2.
- Full: with count=DEPTH, a pop in cycle n frees a slot, so imem_req_valid=1 in cycle n+1. There is no same-cycle slot reuse.
- Same-cycle cases:
  - Request handshake and response in the same cycle: both take effect.
  - Pop and fill of the head in the same cycle: impossible, because only filled entries pop.
- Redirect and output: in the redirect cycle, instr_valid still reflects the old head, but no pop occurs. From cycle +1, instr_valid=0 until the first post-redirect response is filled.
- A redirect in the same cycle as rst is ignored; reset wins.

## Test plan
- Reset/stream: 1-cycle memory, no retain. Expect requests 0x0,0x4,0x8,… and instr_valid from cycle 2 after reset, delivering one instruction per cycle with pc_out matching.
- Full and stall: DEPTH=4, retain held 10 cycles. Expect exactly 4 requests issued and imem_req_valid=0 while full. On release, expect the 4 instructions in order, then the next request at 0x10.
- Variable latency: imem_req_ready toggling and response delays of 1–5 cycles. Expect in-order delivery and pc_out/instr_out pairs matching the memory model.
- Redirect with 3 outstanding: redirect_pc=0x100. Expect those 3 responses dropped, next request addr=0x100, and the first delivered pc_out=0x100. No stale instruction reaches the output.
- Redirect during retain plus same-cycle handshake: expect drop_cnt to include the new request, the queue to be empty next cycle, and the fetch to resume at {redirect_pc[31:2],2'b00}.
- Spurious response with nothing outstanding: expect resp_error=1 and held, with queue unchanged; rst clears it to 0.
